// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO special-register pair.
package hilo_pkg;

    localparam int unsigned HILO_DATA_WIDTH = 32;
    localparam logic [HILO_DATA_WIDTH-1:0] HILO_RESET_VAL = '0;

endpackage

// File: rtl/hi_lo_register_en_reg.sv
// Generic register with synchronous active-high reset, load enable and a power-up value.
module en_reg #(
    parameter int unsigned     Width    = 32,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             writeEnable,
    input  logic [Width-1:0] writeData,
    output logic [Width-1:0] readData
);

    // Declaration initialiser gives a defined value before the first reset or write.
    logic [Width-1:0] regQ = ResetVal;

    always_ff @(posedge clk) begin
        if (reset) begin
            regQ <= ResetVal;
        end else if (writeEnable) begin
            regQ <= writeData;
        end
    end

    assign readData = regQ;

endmodule

// File: rtl/hi_lo_register.sv
// MIPS HI/LO special registers: two independent write-enabled stores with direct read-out.
module hi_lo_register
    import hilo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = HILO_DATA_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  HiWriteEnable,
    input  logic                  LoWriteEnable,
    input  logic [DATA_WIDTH-1:0] HiWriteData,
    input  logic [DATA_WIDTH-1:0] LoWriteData,
    output logic [DATA_WIDTH-1:0] HiReadData,
    output logic [DATA_WIDTH-1:0] LoReadData
);

    en_reg #(
        .Width    (DATA_WIDTH),
        .ResetVal (DATA_WIDTH'(HILO_RESET_VAL))
    ) hiReg (
        .clk         (Clk),
        .reset       (Reset),
        .writeEnable (HiWriteEnable),
        .writeData   (HiWriteData),
        .readData    (HiReadData)
    );

    en_reg #(
        .Width    (DATA_WIDTH),
        .ResetVal (DATA_WIDTH'(HILO_RESET_VAL))
    ) loReg (
        .clk         (Clk),
        .reset       (Reset),
        .writeEnable (LoWriteEnable),
        .writeData   (LoWriteData),
        .readData    (LoReadData)
    );

endmodule

// File: tb/tb_hi_lo_register.sv
// Directed and random checks of hi_lo_register against a scoreboard of expected HI/LO values.
module tb_hi_lo_register;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         hiWe;
    logic         loWe;
    logic [W-1:0] hiWd;
    logic [W-1:0] loWd;
    logic [W-1:0] hiRd;
    logic [W-1:0] loRd;

    logic [W-1:0] hiModel = '0;
    logic [W-1:0] loModel = '0;
    exp_t         expQ[$];
    int           total = 0;
    int           bad = 0;

    hi_lo_register #(
        .DATA_WIDTH (W)
    ) dut (
        .Clk           (clk),
        .Reset         (reset),
        .HiWriteEnable (hiWe),
        .LoWriteEnable (loWe),
        .HiWriteData   (hiWd),
        .LoWriteData   (loWd),
        .HiReadData    (hiRd),
        .LoReadData    (loRd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, record the expected post-edge state, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic hwe, input logic lwe,
                        input logic [W-1:0] hd, input logic [W-1:0] ld);
        exp_t e;
        @(negedge clk);
        reset = r;
        hiWe  = hwe;
        loWe  = lwe;
        hiWd  = hd;
        loWd  = ld;
        if (r) begin
            hiModel = '0;
            loModel = '0;
        end else begin
            if (hwe) hiModel = hd;
            if (lwe) loModel = ld;
        end
        expQ.push_back('{hi: hiModel, lo: loModel});
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard empty observed=%h/%h expected=entry", tag, hiRd, loRd);
        end else begin
            e = expQ.pop_front();
            check({tag, ".hi"}, hiRd, e.hi);
            check({tag, ".lo"}, loRd, e.lo);
        end
    endtask

    initial begin
        reset = 1'b0;
        hiWe  = 1'b0;
        loWe  = 1'b0;
        hiWd  = '0;
        loWd  = '0;

        #1;
        check("powerup.hi", hiRd, 32'h0);
        check("powerup.lo", loRd, 32'h0);
        step("idle", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        step("hiWrite", 1'b0, 1'b1, 1'b0, 32'h7f00, 32'h0);
        step("hiHold1", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step("hiHold2", 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0);

        step("loWrite", 1'b0, 1'b0, 1'b1, 32'h0, 32'h00ff);
        step("bothWrite", 1'b0, 1'b1, 1'b1, 32'h700f, 32'h0ff0);

        step("resetIdle", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step("refill", 1'b0, 1'b1, 1'b1, 32'hdead_beef, 32'hcafe_f00d);
        step("resetPrio", 1'b1, 1'b1, 1'b1, 32'hffff_ffff, 32'hffff_ffff);
        step("afterReset", 1'b0, 1'b0, 1'b0, 32'hffff_ffff, 32'hffff_ffff);

        step("setStable", 1'b0, 1'b1, 1'b1, 32'h1357_9bdf, 32'h2468_ace0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            hiWe = 1'b0;
            loWe = 1'b0;
            hiWd = $urandom;
            loWd = $urandom;
            #1;
            check("noBypass.hi", hiRd, hiModel);
            check("noBypass.lo", loRd, loModel);
            step("dataWiggle", 1'b0, 1'b0, 1'b0, $urandom, $urandom);
        end

        for (int i = 0; i < 24; i++) begin
            step("random", ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                 $urandom, $urandom);
        end

        total++;
        assert (expQ.size() == 0) else begin
            bad++;
            $error("FAIL drain: observed=%0d expected=0", expQ.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
